serial_frame_deser: RTL and testbench
=====================================

# serial_frame_deser

Serial-to-parallel frame receiver that sits directly downstream of the PISO shift stage. It consumes the MSB-first serial bitstream that stage emits and reassembles DATA_W-bit words, with an optional even-parity check. Each completed word is held in a one-entry output buffer and presented on a valid/ready handshake to the consuming logic. The block also reports aborted frames and sticky overrun errors.

## Interface
Parameters:
- DATA_W, 4, data bits per frame (2..16)
- PARITY_EN, 1, 1 = one even-parity bit follows the data bits; 0 = no parity bit

Ports:
- shift_reg_clk  in  1  single clock, all logic on rising edge
- shift_reg_rst  in  1  synchronous, active-high reset
- ser_din  in  1  serial data bit, MSB first
- ser_din_vld  in  1  ser_din carries a valid bit this cycle
- ser_sof  in  1  marks the first bit of a frame; meaningful only with ser_din_vld
- par_dout  out  DATA_W  received word
- par_dout_vld  out  1  par_dout holds an unconsumed word
- par_dout_rdy  in  1  consumer accepts the word when vld&&rdy
- par_err  out  1  parity error for the word on par_dout; 0 when PARITY_EN=0
- frame_abort  out  1  one-cycle pulse when a frame in progress is discarded
- overrun  out  1  sticky: a completed word was dropped
- overrun_clr  in  1  clears overrun

## Operation
- FSM states: IDLE, DATA, PARITY (PARITY_EN=1 only).
- IDLE: bits with ser_din_vld=1 and ser_sof=0 are ignored. On ser_din_vld&&ser_sof: shift in the bit, set bit count to 1, go to DATA. If DATA_W bits are then complete, take the completion path below.
- DATA: each ser_din_vld cycle shifts ser_din into the LSB of the assembly register and shifts the existing bits left. Cycles with ser_din_vld=0 are stalls; state and count hold.
- Completion of bit DATA_W: go to PARITY if PARITY_EN=1. Otherwise the word completes and the FSM returns to IDLE.
- PARITY: the next valid bit is the parity bit. Parity error = XOR of the DATA_W data bits and the parity bit is 1. The word completes and the FSM returns to IDLE.
- ser_sof with ser_din_vld while in DATA or PARITY: the current frame is discarded and frame_abort pulses. The sof bit starts a new frame (count=1, state DATA).
- Word completion loads the output buffer (par_dout, par_err) and sets par_dout_vld, under these conditions:
  - buffer empty;
  - buffer full and par_dout_rdy=1 in the same cycle; the old word is accepted and the new word loaded, and vld stays 1.
- Word completion with the buffer full and par_dout_rdy=0: the new word is dropped, overrun is set, and the buffer is unchanged.
- Handshake: vld&&rdy with no simultaneous completion clears par_dout_vld next cycle. par_dout and par_err must be held stable while vld=1 and rdy=0.
- overrun_clr clears overrun. If overrun_clr and a new overrun occur in the same cycle, the set wins.
- Bit count width: clog2(DATA_W+1). The count resets to 0 on every return to IDLE.

## Timing
- Reset (shift_reg_rst=1 at a clock edge) sets: FSM=IDLE, count=0, par_dout=0, par_dout_vld=0, par_err=0, frame_abort=0, overrun=0.
- Reset mid-frame discards the partial word without a frame_abort pulse. Reset also discards a buffered, unaccepted word.
- Latency: par_dout_vld rises 1 cycle after the edge that samples the final bit. That final bit is the parity bit when PARITY_EN=1, otherwise data bit DATA_W.
- Minimum frame period with no stalls: DATA_W+PARITY_EN cycles. Back-to-back frames with rdy held high sustain full throughput with no bubble.
- frame_abort is registered and asserts 1 cycle after the offending ser_sof sample, for exactly 1 cycle.
- overrun asserts 1 cycle after the dropped completion.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
All scenarios use DATA_W=4 and PARITY_EN=1 unless noted.
- Reset, then frame 1,1,0,1 (sof on first bit) plus parity 1, contiguous vld, rdy=1 -> par_dout=4'b1101, par_err=0, vld high 1 cycle after the parity sample, low the following cycle.
- Frame 1,0,1,1 plus parity 0 -> par_dout=4'b1011, par_err=1; with PARITY_EN=0, frame 1,0,1,1 -> 4'b1011, vld 1 cycle after the 4th bit, par_err=0.
- Frame 1,1,0,1,p=1 with ser_din_vld low for 3 cycles between bits 2 and 3 -> par_dout=4'b1101, vld delayed by exactly 3 cycles relative to the contiguous case.
- Bits 1,0 then sof with new frame 0,1,1,0,p=0 -> frame_abort single pulse, par_dout=4'b0110, par_err=0, no output for the aborted frame.
- rdy=0; frames 4'b1101 then 4'b0011 back-to-back -> par_dout stays 4'b1101, overrun=1 after the second completes; overrun_clr -> overrun=0; raise rdy -> 4'b1101 accepted, vld drops.
- Assert shift_reg_rst after 2 data bits -> all outputs 0 next cycle; a following clean frame 4'b1001,p=0 decodes correctly.

Source files
------------

// File: rtl/serial_frame_deser.sv
// serial_frame_deser
// Reassembles an MSB-first serial bitstream into DATA_W-bit words with an
// optional trailing even-parity bit. Completed words sit in a one-entry
// output buffer presented on a valid/ready handshake. Aborted frames pulse
// frame_abort; words that complete into a full, stalled buffer set the
// sticky overrun flag.
//
// Handshake: par_dout_vld=1 means par_dout/par_err hold an unconsumed word.
// The word is transferred on any rising edge where par_dout_vld and
// par_dout_rdy are both 1. While vld=1 and rdy=0 the word and its error
// flag are held stable; vld never drops without a transfer (except reset).
module serial_frame_deser #(
    parameter int DATA_W    = 4,
    parameter int PARITY_EN = 1
) (
    input  logic              shift_reg_clk,
    input  logic              shift_reg_rst,
    input  logic              ser_din,
    input  logic              ser_din_vld,
    input  logic              ser_sof,
    output logic [DATA_W-1:0] par_dout,
    output logic              par_dout_vld,
    input  logic              par_dout_rdy,
    output logic              par_err,
    output logic              frame_abort,
    output logic              overrun,
    input  logic              overrun_clr,
    output logic [1:0]        dbg_state
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2
    } state_t;

    // Frame assembly state
    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_shift;

    // Output buffer and status
    logic [DATA_W-1:0]   r_dout;
    logic                r_dout_vld;
    logic                r_err;
    logic                r_abort;
    logic                r_overrun;

    // Next-state / event wires from the combinational half of the FSM
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [DATA_W-1:0]   w_shift_nxt;
    logic [DATA_W-1:0]   w_shift_in;
    logic                w_complete;
    logic [DATA_W-1:0]   w_word;
    logic                w_word_err;
    logic                w_abort;
    logic                w_load;
    logic                w_drop;

    // Incoming bit enters at the LSB, earlier bits move toward the MSB.
    assign w_shift_in = {r_shift[DATA_W-2:0], ser_din};

    // FSM state register and assembly datapath
    always_ff @(posedge shift_reg_clk) begin
        if (shift_reg_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    // Next-state, bit counting, word completion and abort detection
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        w_complete  = 1'b0;
        w_word      = r_shift;
        w_word_err  = 1'b0;
        w_abort     = 1'b0;

        if (ser_din_vld) begin
            if (ser_sof) begin
                // A start-of-frame always restarts assembly; anything in
                // flight is thrown away and reported.
                w_abort     = (r_state != S_IDLE);
                w_shift_nxt = {{(DATA_W-1){1'b0}}, ser_din};
                w_cnt_nxt   = CNT_W'(1);
                w_state_nxt = S_DATA;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        // Bits outside a frame are ignored.
                    end
                    S_DATA: begin
                        w_shift_nxt = w_shift_in;
                        w_cnt_nxt   = r_cnt + 1'b1;
                        if (r_cnt == LAST_CNT) begin
                            if (PARITY_EN != 0) begin
                                w_state_nxt = S_PARITY;
                            end else begin
                                w_complete  = 1'b1;
                                w_word      = w_shift_in;
                                w_word_err  = 1'b0;
                                w_cnt_nxt   = '0;
                                w_state_nxt = S_IDLE;
                            end
                        end
                    end
                    S_PARITY: begin
                        // Even parity: data bits plus parity bit must XOR to 0.
                        w_complete  = 1'b1;
                        w_word      = r_shift;
                        w_word_err  = (PARITY_EN != 0) && ((^r_shift) ^ ser_din);
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_IDLE;
                    end
                    default: begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_IDLE;
                    end
                endcase
            end
        end
    end

    // A completed word enters the buffer if it is empty or being drained
    // this very cycle; otherwise it is dropped and flagged as an overrun.
    assign w_load = w_complete && (!r_dout_vld || par_dout_rdy);
    assign w_drop = w_complete && r_dout_vld && !par_dout_rdy;

    // One-entry output buffer with valid/ready handshake
    always_ff @(posedge shift_reg_clk) begin
        if (shift_reg_rst) begin
            r_dout     <= '0;
            r_err      <= 1'b0;
            r_dout_vld <= 1'b0;
        end else if (w_load) begin
            r_dout     <= w_word;
            r_err      <= w_word_err;
            r_dout_vld <= 1'b1;
        end else if (r_dout_vld && par_dout_rdy) begin
            r_dout_vld <= 1'b0;
        end
    end

    // Registered one-cycle abort pulse
    always_ff @(posedge shift_reg_clk) begin
        if (shift_reg_rst) begin
            r_abort <= 1'b0;
        end else begin
            r_abort <= w_abort;
        end
    end

    // Sticky overrun flag; a new drop beats a simultaneous clear
    always_ff @(posedge shift_reg_clk) begin
        if (shift_reg_rst) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (overrun_clr) begin
            r_overrun <= 1'b0;
        end
    end

    assign par_dout     = r_dout;
    assign par_dout_vld = r_dout_vld;
    assign par_err      = r_err;
    assign frame_abort  = r_abort;
    assign overrun      = r_overrun;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_serial_frame_deser.sv
// Directed testbench for serial_frame_deser (DATA_W=4, with and without parity).
module tb_serial_frame_deser;

    localparam int W = 4;

    logic         clk;
    logic         shift_reg_rst;

    // Instance with parity
    logic         ser_din;
    logic         ser_din_vld;
    logic         ser_sof;
    logic [W-1:0] par_dout;
    logic         par_dout_vld;
    logic         par_dout_rdy;
    logic         par_err;
    logic         frame_abort;
    logic         overrun;
    logic         overrun_clr;
    logic [1:0]   dbg_state;

    // Instance without parity
    logic         ser_din2;
    logic         ser_din_vld2;
    logic         ser_sof2;
    logic [W-1:0] par_dout2;
    logic         par_dout_vld2;
    logic         par_dout_rdy2;
    logic         par_err2;
    logic         frame_abort2;
    logic         overrun2;
    logic         overrun_clr2;
    logic [1:0]   dbg_state2;

    int n_checks;
    int n_errors;
    logic [W-1:0] exp_q[$];

    serial_frame_deser #(.DATA_W(W), .PARITY_EN(1)) dut (
        .shift_reg_clk (clk),
        .shift_reg_rst (shift_reg_rst),
        .ser_din       (ser_din),
        .ser_din_vld   (ser_din_vld),
        .ser_sof       (ser_sof),
        .par_dout      (par_dout),
        .par_dout_vld  (par_dout_vld),
        .par_dout_rdy  (par_dout_rdy),
        .par_err       (par_err),
        .frame_abort   (frame_abort),
        .overrun       (overrun),
        .overrun_clr   (overrun_clr),
        .dbg_state     (dbg_state)
    );

    serial_frame_deser #(.DATA_W(W), .PARITY_EN(0)) dut_np (
        .shift_reg_clk (clk),
        .shift_reg_rst (shift_reg_rst),
        .ser_din       (ser_din2),
        .ser_din_vld   (ser_din_vld2),
        .ser_sof       (ser_sof2),
        .par_dout      (par_dout2),
        .par_dout_vld  (par_dout_vld2),
        .par_dout_rdy  (par_dout_rdy2),
        .par_err       (par_err2),
        .frame_abort   (frame_abort2),
        .overrun       (overrun2),
        .overrun_clr   (overrun_clr2),
        .dbg_state     (dbg_state2)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance one clock; return just after the edge so outputs are settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic sof);
        ser_din     = b;
        ser_sof     = sof;
        ser_din_vld = 1'b1;
        tick();
    endtask

    task automatic send_bit2(input logic b, input logic sof);
        ser_din2     = b;
        ser_sof2     = sof;
        ser_din_vld2 = 1'b1;
        tick();
    endtask

    task automatic idle(input int n);
        ser_din_vld  = 1'b0;
        ser_sof      = 1'b0;
        ser_din      = 1'b0;
        ser_din_vld2 = 1'b0;
        ser_sof2     = 1'b0;
        ser_din2     = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_dout"},    16'(par_dout),     16'h0);
        check_val({tag, "_vld"},     16'(par_dout_vld), 16'h0);
        check_val({tag, "_err"},     16'(par_err),      16'h0);
        check_val({tag, "_abort"},   16'(frame_abort),  16'h0);
        check_val({tag, "_overrun"}, 16'(overrun),      16'h0);
    endtask

    // Scoreboard: every word handed over on vld&&rdy must match the queue head.
    always @(negedge clk) begin
        if (!shift_reg_rst && par_dout_vld && par_dout_rdy) begin
            if (exp_q.size() == 0) begin
                check_val("sb_extra_word", 16'(par_dout), 16'hFFFF);
            end else begin
                check_val("sb_word", 16'(par_dout), 16'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        shift_reg_rst = 1'b1;
        ser_din       = 1'b0;
        ser_din_vld   = 1'b0;
        ser_sof       = 1'b0;
        par_dout_rdy  = 1'b1;
        overrun_clr   = 1'b0;
        ser_din2      = 1'b0;
        ser_din_vld2  = 1'b0;
        ser_sof2      = 1'b0;
        par_dout_rdy2 = 1'b1;
        overrun_clr2  = 1'b0;

        tick();
        tick();
        shift_reg_rst = 1'b0;
        check_reset_outputs("rst");

        // Frame 1101, parity 1 (even) -> no error
        exp_q.push_back(4'b1101);
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        check_val("t1_vld_before_par", 16'(par_dout_vld), 16'h0);
        send_bit(1'b1, 1'b0);
        check_val("t1_vld", 16'(par_dout_vld), 16'h1);
        check_val("t1_dout", 16'(par_dout), 16'hD);
        check_val("t1_err", 16'(par_err), 16'h0);
        idle(1);
        check_val("t1_vld_drop", 16'(par_dout_vld), 16'h0);
        idle(1);

        // Frame 1011, parity 0 -> odd overall, error
        exp_q.push_back(4'b1011);
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        check_val("t2_vld", 16'(par_dout_vld), 16'h1);
        check_val("t2_dout", 16'(par_dout), 16'hB);
        check_val("t2_err", 16'(par_err), 16'h1);
        idle(2);

        // No-parity instance: 1011 completes on the 4th bit
        send_bit2(1'b1, 1'b1);
        send_bit2(1'b0, 1'b0);
        send_bit2(1'b1, 1'b0);
        check_val("np_vld_early", 16'(par_dout_vld2), 16'h0);
        send_bit2(1'b1, 1'b0);
        check_val("np_vld", 16'(par_dout_vld2), 16'h1);
        check_val("np_dout", 16'(par_dout2), 16'hB);
        check_val("np_err", 16'(par_err2), 16'h0);
        idle(2);
        check_val("np_vld_drop", 16'(par_dout_vld2), 16'h0);

        // Stalled frame 1101: three idle cycles between bits 2 and 3
        exp_q.push_back(4'b1101);
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        idle(3);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        check_val("t3_vld_before_par", 16'(par_dout_vld), 16'h0);
        send_bit(1'b1, 1'b0);
        check_val("t3_vld", 16'(par_dout_vld), 16'h1);
        check_val("t3_dout", 16'(par_dout), 16'hD);
        check_val("t3_err", 16'(par_err), 16'h0);
        idle(2);

        // Abort: bits 1,0 then a new sof frame 0110, parity 0
        exp_q.push_back(4'b0110);
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        check_val("t4_abort_pre", 16'(frame_abort), 16'h0);
        send_bit(1'b0, 1'b1);
        check_val("t4_abort", 16'(frame_abort), 16'h1);
        send_bit(1'b1, 1'b0);
        check_val("t4_abort_end", 16'(frame_abort), 16'h0);
        check_val("t4_no_word", 16'(par_dout_vld), 16'h0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        check_val("t4_vld", 16'(par_dout_vld), 16'h1);
        check_val("t4_dout", 16'(par_dout), 16'h6);
        check_val("t4_err", 16'(par_err), 16'h0);
        idle(2);

        // Overrun: consumer stalled, 1101 then 0011 back to back
        par_dout_rdy = 1'b0;
        exp_q.push_back(4'b1101);
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        check_val("t5_vld", 16'(par_dout_vld), 16'h1);
        check_val("t5_overrun_pre", 16'(overrun), 16'h0);
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        check_val("t5_overrun", 16'(overrun), 16'h1);
        check_val("t5_dout_held", 16'(par_dout), 16'hD);
        check_val("t5_vld_held", 16'(par_dout_vld), 16'h1);
        idle(1);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        check_val("t5_overrun_clr", 16'(overrun), 16'h0);
        par_dout_rdy = 1'b1;
        tick();
        check_val("t5_vld_drop", 16'(par_dout_vld), 16'h0);
        idle(1);

        // Reset mid-frame, then a clean frame 1001, parity 0
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        idle(0);
        shift_reg_rst = 1'b1;
        tick();
        shift_reg_rst = 1'b0;
        check_reset_outputs("t6_rst");
        tick();
        check_val("t6_no_abort", 16'(frame_abort), 16'h0);
        exp_q.push_back(4'b1001);
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        check_val("t6_vld", 16'(par_dout_vld), 16'h1);
        check_val("t6_dout", 16'(par_dout), 16'h9);
        check_val("t6_err", 16'(par_err), 16'h0);
        idle(3);

        check_val("sb_drain", 16'(exp_q.size()), 16'h0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
